bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Three-master bus arbiter (CPU, DMA0, DMA1) with DMA burst limiting, DMA round-robin,
// back-to-back handover on xfer_done, abort on request drop and ownership timeout.

module bus_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       dma0_req,
    input  logic       dma1_req,
    input  logic       xfer_done,
    output logic       cpu_grant,
    output logic       dma0_grant,
    output logic       dma1_grant,
    output logic [1:0] owner,
    output logic       sel_dma,
    output logic       arb_timeout
);

    localparam int BW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX   = BW'(MAX_BURST);
    localparam logic [BW-1:0] BURST_ONE   = BW'(1);
    localparam logic [BW-1:0] BURST_ZERO  = BW'(0);
    localparam logic [3:0]    TIMEOUT_CNT = 4'(TIMEOUT);

    // State encoding doubles as the owner code.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_DMA0 = 2'b10,
        OWN_DMA1 = 2'b11
    } state_t;

    state_t         state_r;
    state_t         state_s;
    state_t         arb_s;
    logic           arb_en_s;
    logic           owner_req_s;
    logic           timeout_s;
    logic           burst_full_s;
    logic [3:0]     tmo_cnt_r;
    logic [3:0]     tmo_cnt_s;
    logic [BW-1:0]  burst_cnt_r;
    logic [BW-1:0]  burst_cnt_s;
    logic           favour_d1_r;
    logic           favour_d1_s;

    logic           cpu_grant_r;
    logic           dma0_grant_r;
    logic           dma1_grant_r;
    logic [1:0]     owner_r;
    logic           sel_dma_r;
    logic           arb_timeout_r;

    // CPU only beats DMA once the burst allowance is spent; DMA pair is round-robin.
    function automatic state_t arbitrate(
        input logic cpu,
        input logic d0,
        input logic d1,
        input logic burst_full,
        input logic favour_d1
    );
        state_t res;
        if (cpu && burst_full) begin
            res = OWN_CPU;
        end else if (d0 && d1) begin
            res = favour_d1 ? OWN_DMA1 : OWN_DMA0;
        end else if (d0) begin
            res = OWN_DMA0;
        end else if (d1) begin
            res = OWN_DMA1;
        end else if (cpu) begin
            res = OWN_CPU;
        end else begin
            res = IDLE;
        end
        return res;
    endfunction

    assign burst_full_s = (burst_cnt_r == BURST_MAX);

    // Arbitration result and the current owner's request line.
    always_comb begin
        arb_s = arbitrate(cpu_req, dma0_req, dma1_req, burst_full_s, favour_d1_r);
        owner_req_s = 1'b0;
        case (state_r)
            OWN_CPU:  owner_req_s = cpu_req;
            OWN_DMA0: owner_req_s = dma0_req;
            OWN_DMA1: owner_req_s = dma1_req;
            default:  owner_req_s = 1'b0;
        endcase
    end

    // Next-state: completion beats abort, abort beats timeout.
    always_comb begin
        state_s   = state_r;
        arb_en_s  = 1'b0;
        timeout_s = 1'b0;
        if (state_r == IDLE) begin
            arb_en_s = 1'b1;
            state_s  = arb_s;
        end else if (xfer_done) begin
            arb_en_s = 1'b1;
            state_s  = arb_s;
        end else if (!owner_req_s) begin
            state_s = IDLE;
        end else if (tmo_cnt_r == TIMEOUT_CNT) begin
            state_s   = IDLE;
            timeout_s = 1'b1;
        end else begin
            state_s = state_r;
        end
    end

    // Ownership counter, burst counter and round-robin pointer updates.
    always_comb begin
        tmo_cnt_s   = tmo_cnt_r;
        burst_cnt_s = burst_cnt_r;
        favour_d1_s = favour_d1_r;

        if ((state_s == IDLE) || xfer_done || (state_s != state_r)) begin
            tmo_cnt_s = 4'd0;
        end else begin
            tmo_cnt_s = tmo_cnt_r + 4'd1;
        end

        if (!cpu_req) begin
            burst_cnt_s = BURST_ZERO;
        end else if (arb_en_s && (arb_s == OWN_CPU)) begin
            burst_cnt_s = BURST_ZERO;
        end else if (arb_en_s && ((arb_s == OWN_DMA0) || (arb_s == OWN_DMA1))) begin
            if (burst_full_s) begin
                burst_cnt_s = BURST_MAX;
            end else begin
                burst_cnt_s = burst_cnt_r + BURST_ONE;
            end
        end else begin
            burst_cnt_s = burst_cnt_r;
        end

        if (arb_en_s && (arb_s == OWN_DMA0)) begin
            favour_d1_s = 1'b1;
        end else if (arb_en_s && (arb_s == OWN_DMA1)) begin
            favour_d1_s = 1'b0;
        end else begin
            favour_d1_s = favour_d1_r;
        end
    end

    // State, counters and output registers; outputs are decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            tmo_cnt_r     <= 4'd0;
            burst_cnt_r   <= BURST_ZERO;
            favour_d1_r   <= 1'b0;
            cpu_grant_r   <= 1'b0;
            dma0_grant_r  <= 1'b0;
            dma1_grant_r  <= 1'b0;
            owner_r       <= 2'b00;
            sel_dma_r     <= 1'b0;
            arb_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            tmo_cnt_r     <= tmo_cnt_s;
            burst_cnt_r   <= burst_cnt_s;
            favour_d1_r   <= favour_d1_s;
            cpu_grant_r   <= (state_s == OWN_CPU);
            dma0_grant_r  <= (state_s == OWN_DMA0);
            dma1_grant_r  <= (state_s == OWN_DMA1);
            owner_r       <= state_s;
            sel_dma_r     <= state_s[1];
            arb_timeout_r <= timeout_s;
        end
    end

    assign cpu_grant   = cpu_grant_r;
    assign dma0_grant  = dma0_grant_r;
    assign dma1_grant  = dma1_grant_r;
    assign owner       = owner_r;
    assign sel_dma     = sel_dma_r;
    assign arb_timeout = arb_timeout_r;

    bus_arbiter_checker u_checker (
        .clk         (clk),
        .reset       (reset),
        .cpu_grant   (cpu_grant_r),
        .dma0_grant  (dma0_grant_r),
        .dma1_grant  (dma1_grant_r),
        .owner       (owner_r),
        .sel_dma     (sel_dma_r),
        .arb_timeout (arb_timeout_r)
    );

endmodule

// Output consistency properties for bus_arbiter.
module bus_arbiter_checker (
    input logic       clk,
    input logic       reset,
    input logic       cpu_grant,
    input logic       dma0_grant,
    input logic       dma1_grant,
    input logic [1:0] owner,
    input logic       sel_dma,
    input logic       arb_timeout
);

    a_grant_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0({cpu_grant, dma0_grant, dma1_grant}));

    a_owner_decode: assert property (@(posedge clk) disable iff (reset)
        (cpu_grant == (owner == 2'b01)) && (dma0_grant == (owner == 2'b10)) &&
        (dma1_grant == (owner == 2'b11)));

    a_sel_dma: assert property (@(posedge clk) disable iff (reset)
        sel_dma == (dma0_grant || dma1_grant));

    a_timeout_idle: assert property (@(posedge clk) disable iff (reset)
        arb_timeout |-> (owner == 2'b00));

    a_timeout_pulse: assert property (@(posedge clk) disable iff (reset)
        arb_timeout |=> !arb_timeout);

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: vector table plus timeout sequences,
// expected outputs queued at drive time and compared one cycle later.

module tb_bus_arbiter;

    logic       clk;
    logic       reset;
    logic       cpu_req;
    logic       dma0_req;
    logic       dma1_req;
    logic       xfer_done;
    logic       cpu_grant;
    logic       dma0_grant;
    logic       dma1_grant;
    logic [1:0] owner;
    logic       sel_dma;
    logic       arb_timeout;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        logic       rst;
        logic       cpu;
        logic       d0;
        logic       d1;
        logic       done;
        logic [1:0] eo;
        logic       et;
    } vec_t;

    typedef struct {
        string      name;
        logic [6:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];

    bus_arbiter #(.MAX_BURST(4), .TIMEOUT(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .dma0_req    (dma0_req),
        .dma1_req    (dma1_req),
        .xfer_done   (xfer_done),
        .cpu_grant   (cpu_grant),
        .dma0_grant  (dma0_grant),
        .dma1_grant  (dma1_grant),
        .owner       (owner),
        .sel_dma     (sel_dma),
        .arb_timeout (arb_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    // Grants/sel_dma follow from the owner code: 01 CPU, 10 DMA0, 11 DMA1.
    function automatic logic [6:0] pack_exp(input logic [1:0] own, input logic tmo);
        return {own == 2'b01, own == 2'b10, own == 2'b11, own, own[1], tmo};
    endfunction

    function automatic void add(input string nm, input logic r, input logic c,
                                input logic a, input logic b, input logic d,
                                input logic [1:0] eo, input logic et);
        vec_t v;
        v.name = nm; v.rst = r; v.cpu = c; v.d0 = a; v.d1 = b; v.done = d;
        v.eo = eo; v.et = et;
        vecs.push_back(v);
    endfunction

    task automatic check_out();
        sb_t        e;
        logic [6:0] act;
        act = {cpu_grant, dma0_grant, dma1_grant, owner, sel_dma, arb_timeout};
        e = sb_q.pop_front();
        total++;
        if (act !== e.exp) begin
            bad++;
            $display("FAIL %s: got {cg,d0g,d1g,owner,sel,tmo}=%b required %b at %0t",
                     e.name, act, e.exp, $time);
        end
    endtask

    task automatic step(input string nm, input logic r, input logic c, input logic a,
                        input logic b, input logic d, input logic [1:0] eo, input logic et);
        sb_t e;
        e.name = nm;
        e.exp  = pack_exp(eo, et);
        sb_q.push_back(e);
        reset = r; cpu_req = c; dma0_req = a; dma1_req = b; xfer_done = d;
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        //   name            rst cpu d0 d1 done owner tmo
        add("rst0",         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        add("rst_with_req", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        add("cpu_grant",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
        add("cpu_hold1",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
        add("cpu_hold2",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
        add("cpu_done",     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        add("idle_done",    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        add("rr_d0",        1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
        add("rr_d1",        1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0);
        add("rr_d1_hold",   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0);
        add("rr_d0_again",  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0);
        add("rr_d0_hold",   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
        add("rr_d1_again",  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0);
        add("rr_release",   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        add("burst1",       1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
        add("burst2",       1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
        add("burst3",       1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
        add("burst4",       1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
        add("burst_cpu",    1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0);
        add("burst_dma0",   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
        add("burst_rel",    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        add("d1_grant",     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0);
        add("d1_abort",     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        add("d0_grant",     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
        add("d0_regrant",   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
        add("d0_hold",      1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
        add("abort_no_arb", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        add("cpu_after_ab", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
        add("cpu_to_d0",    1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
        add("rst_mid_xfer", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
        add("post_rst_d0",  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
        add("post_rst_d1",  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0);
        add("post_rst_rel", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        add("bclr_1",       1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
        add("bclr_2",       1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
        add("bclr_3",       1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
        add("bclr_cpu_off", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
        add("bclr_r1",      1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
        add("bclr_r2",      1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
        add("bclr_r3",      1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
        add("bclr_r4",      1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
        add("bclr_cpu",     1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0);
        add("bclr_rel",     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);

        reset = 1'b1; cpu_req = 1'b0; dma0_req = 1'b0; dma1_req = 1'b0; xfer_done = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].name, vecs[i].rst, vecs[i].cpu, vecs[i].d0, vecs[i].d1,
                 vecs[i].done, vecs[i].eo, vecs[i].et);
        end

        // Timeout: DMA1 holds without completion until the counter reaches 15.
        step("tmo_grant", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0);
        for (int k = 0; k < 15; k++) begin
            step("tmo_hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0);
        end
        step("tmo_pulse", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1);
        step("tmo_clear", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);

        // Completion on the same cycle the counter hits 15 hands over normally.
        step("race_grant", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0);
        for (int k = 0; k < 15; k++) begin
            step("race_hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0);
        end
        step("race_done", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
        step("race_rel", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
